// File: rtl/alu_arith_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_arith_arbiter_pkg
// Shared definitions for the ALU blocks: op-select encodings, FSM state
// encodings, operand width and the packed request bundle.
// ---------------------------------------------------------------------------
package alu_arith_arbiter_pkg;

    localparam int DATA_W = 8;

    // Two-bit op select carried on REQn_S.
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_INC  = 2'b10,
        OP_PASS = 2'b11
    } alu_op_e;

    // Handshake FSM: arbitrate in IDLE, hold one result in RESP.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } alu_state_e;

    // One requester's operation as seen by the arithmetic datapath.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        alu_op_e           op;
    } alu_req_t;

endpackage

// File: rtl/alu_arith_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter, purely combinational.
//   req   in  2  request pair, bit n = requester n
//   ptr   in  1  favoured requester when both request
//   grant out 2  one-hot grant (all zero when nobody requests)
// ---------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned; otherwise a latch is inferred.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arith_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arith_arbiter
// Two requesters share one 8-bit add/sub/inc/pass unit. A round-robin
// arbiter picks one request in IDLE, the result is registered and held in
// RESP until the owning requester consumes it.
//   CLK, RST                      clock, async active-high reset
//   REQn_VALID/READY              request handshake per requester
//   REQn_A, REQn_B, REQn_S        operands and op select
//   RSPn_VALID/READY              response handshake per requester
//   RSP_OUT, RSP_C_OUT,           shared result byte, carry (sum bit 8)
//   RSP_OVERFLOW                  and signed overflow
// ---------------------------------------------------------------------------
module alu_arith_arbiter
    import alu_arith_arbiter_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ0_VALID,
    input  logic       REQ1_VALID,
    output logic       REQ0_READY,
    output logic       REQ1_READY,
    input  logic [7:0] REQ0_A,
    input  logic [7:0] REQ1_A,
    input  logic [7:0] REQ0_B,
    input  logic [7:0] REQ1_B,
    input  logic [1:0] REQ0_S,
    input  logic [1:0] REQ1_S,
    output logic       RSP0_VALID,
    output logic       RSP1_VALID,
    input  logic       RSP0_READY,
    input  logic       RSP1_READY,
    output logic [7:0] RSP_OUT,
    output logic       RSP_C_OUT,
    output logic       RSP_OVERFLOW
);

    alu_state_e        state;
    logic              ptr;
    logic [1:0]        rsp_valid;
    logic [DATA_W-1:0] rsp_out;
    logic              rsp_c_out;
    logic              rsp_overflow;

    logic [1:0]        grant;
    alu_req_t          sel;
    logic [DATA_W-1:0] summand;
    logic              cin;
    logic [DATA_W:0]   sum;
    logic              overflow;

    rr_arbiter2 u_arb (
        .req   ({REQ1_VALID, REQ0_VALID}),
        .ptr   (ptr),
        .grant (grant)
    );

    // Acceptance is only possible while idle; RESP blocks both requesters.
    assign REQ0_READY = (state == ST_IDLE) && grant[0];
    assign REQ1_READY = (state == ST_IDLE) && grant[1];

    // Operand mux follows the grant; with no grant the values are unused.
    always_comb begin
        if (grant[1]) begin
            sel = '{a: REQ1_A, b: REQ1_B, op: alu_op_e'(REQ1_S)};
        end else begin
            sel = '{a: REQ0_A, b: REQ0_B, op: alu_op_e'(REQ0_S)};
        end
    end

    // Every op is A + summand + cin so a single adder serves all four.
    always_comb begin
        summand = '0;
        cin     = 1'b0;
        unique case (sel.op)
            OP_ADD:  begin summand = sel.b;  cin = 1'b0; end
            OP_SUB:  begin summand = ~sel.b; cin = 1'b1; end
            OP_INC:  begin summand = '0;     cin = 1'b1; end
            OP_PASS: begin summand = '0;     cin = 1'b0; end
        endcase
        sum      = {1'b0, sel.a} + {1'b0, summand} + {{DATA_W{1'b0}}, cin};
        overflow = (sel.a[DATA_W-1] == summand[DATA_W-1]) &&
                   (sum[DATA_W-1] != sel.a[DATA_W-1]);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= ST_IDLE;
            ptr          <= 1'b0;
            rsp_valid    <= 2'b00;
            rsp_out      <= '0;
            rsp_c_out    <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        rsp_out      <= sum[DATA_W-1:0];
                        rsp_c_out    <= sum[DATA_W];
                        rsp_overflow <= overflow;
                        rsp_valid    <= grant;
                        // Favour whoever was not served this time.
                        ptr          <= grant[0];
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Only the owner's ready matters; rsp_valid masks the other.
                    if ((rsp_valid & {RSP1_READY, RSP0_READY}) != 2'b00) begin
                        rsp_valid <= 2'b00;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign RSP0_VALID   = rsp_valid[0];
    assign RSP1_VALID   = rsp_valid[1];
    assign RSP_OUT      = rsp_out;
    assign RSP_C_OUT    = rsp_c_out;
    assign RSP_OVERFLOW = rsp_overflow;

endmodule

// File: tb/tb_alu_arith_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arith_arbiter
// Directed stimulus pushes hand-computed expected responses into a queue;
// a monitor pops and compares on every response handshake.
// ---------------------------------------------------------------------------
module tb_alu_arith_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       REQ0_VALID, REQ1_VALID;
    logic       REQ0_READY, REQ1_READY;
    logic [7:0] REQ0_A, REQ1_A, REQ0_B, REQ1_B;
    logic [1:0] REQ0_S, REQ1_S;
    logic       RSP0_VALID, RSP1_VALID;
    logic       RSP0_READY, RSP1_READY;
    logic [7:0] RSP_OUT;
    logic       RSP_C_OUT, RSP_OVERFLOW;

    typedef struct {
        int         owner;
        logic [7:0] out;
        logic       c;
        logic       ov;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 CLK = ~CLK;

    alu_arith_arbiter dut (
        .CLK          (CLK),
        .RST          (RST),
        .REQ0_VALID   (REQ0_VALID),
        .REQ1_VALID   (REQ1_VALID),
        .REQ0_READY   (REQ0_READY),
        .REQ1_READY   (REQ1_READY),
        .REQ0_A       (REQ0_A),
        .REQ1_A       (REQ1_A),
        .REQ0_B       (REQ0_B),
        .REQ1_B       (REQ1_B),
        .REQ0_S       (REQ0_S),
        .REQ1_S       (REQ1_S),
        .RSP0_VALID   (RSP0_VALID),
        .RSP1_VALID   (RSP1_VALID),
        .RSP0_READY   (RSP0_READY),
        .RSP1_READY   (RSP1_READY),
        .RSP_OUT      (RSP_OUT),
        .RSP_C_OUT    (RSP_C_OUT),
        .RSP_OVERFLOW (RSP_OVERFLOW)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Monitor: compare on each response handshake, in issue order.
    always @(negedge CLK) begin
        if (!RST && (RSP0_VALID || RSP1_VALID)) begin
            check("rsp_onehot", {30'b0, RSP1_VALID, RSP0_VALID} == 32'd3, 32'd0);
            if ((RSP0_VALID && RSP0_READY) || (RSP1_VALID && RSP1_READY)) begin
                if (sb.size() == 0) begin
                    timeout_fail("sb_unexpected_rsp");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_owner", RSP1_VALID ? 32'd1 : 32'd0, e.owner);
                    check("rsp_out", {24'b0, RSP_OUT}, {24'b0, e.out});
                    check("rsp_c_out", {31'b0, RSP_C_OUT}, {31'b0, e.c});
                    check("rsp_overflow", {31'b0, RSP_OVERFLOW}, {31'b0, e.ov});
                end
            end
        end
    end

    task automatic drive(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] s);
        if (idx == 0) begin
            REQ0_A = a; REQ0_B = b; REQ0_S = s; REQ0_VALID = 1'b1;
        end else begin
            REQ1_A = a; REQ1_B = b; REQ1_S = s; REQ1_VALID = 1'b1;
        end
    endtask

    task automatic push(input int owner, input logic [7:0] out, input logic c, input logic ov);
        exp_t e;
        e.owner = owner; e.out = out; e.c = c; e.ov = ov;
        sb.push_back(e);
    endtask

    // Waits (bounded) for an accept and checks that the expected requester won.
    task automatic wait_grant(input int exp_idx);
        bit seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (REQ0_READY || REQ1_READY) begin
                check("grant", {30'b0, REQ1_READY, REQ0_READY},
                      (exp_idx == 0) ? 32'd1 : 32'd2);
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout_fail("grant_wait");
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            #1;
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout_fail("drain");
    endtask

    // Single-requester transaction with immediate consumption.
    task automatic single(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] s, input logic [7:0] out,
                          input logic c, input logic ov);
        drive(idx, a, b, s);
        push(idx, out, c, ov);
        wait_grant(idx);
        @(posedge CLK); #1;
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        drain();
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        REQ0_A = '0; REQ0_B = '0; REQ0_S = '0;
        REQ1_A = '0; REQ1_B = '0; REQ1_S = '0;
        RSP0_READY = 1'b1; RSP1_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Reset state.
        @(negedge CLK);
        check("rst_rsp_valid", {30'b0, RSP1_VALID, RSP0_VALID}, 32'd0);
        check("rst_out", {24'b0, RSP_OUT}, 32'h00);
        check("rst_c_ov", {30'b0, RSP_C_OUT, RSP_OVERFLOW}, 32'd0);
        check("rst_req_ready", {30'b0, REQ1_READY, REQ0_READY}, 32'd0);
        @(posedge CLK); #1;

        // Directed arithmetic through single requesters.
        single(0, 8'h7F, 8'h01, 2'b00, 8'h80, 1'b0, 1'b1);
        single(1, 8'h05, 8'h07, 2'b01, 8'hFE, 1'b0, 1'b0);
        single(1, 8'h80, 8'h01, 2'b01, 8'h7F, 1'b1, 1'b1);
        single(0, 8'hFF, 8'h00, 2'b10, 8'h00, 1'b1, 1'b0);
        single(1, 8'h3C, 8'h55, 2'b11, 8'h3C, 1'b0, 1'b0);

        // Both valid continuously after reset: grants alternate 0,1,0,1.
        pulse_reset();
        drive(0, 8'h10, 8'h20, 2'b00);   // 0x30
        drive(1, 8'h50, 8'h30, 2'b01);   // 0x50-0x30 = 0x20, no borrow -> carry 1
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push(0, 8'h30, 1'b0, 1'b0);
            else            push(1, 8'h20, 1'b1, 1'b0);
        end
        for (int k = 0; k < 4; k++) wait_grant(k % 2);
        @(posedge CLK); #1;
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        drain();

        // Owner 0 stalls for 5 cycles while requester 1 waits; RSP1_READY=1
        // on the non-owner must be ignored.
        RSP0_READY = 1'b0;
        RSP1_READY = 1'b1;
        drive(0, 8'h01, 8'h02, 2'b00);
        push(0, 8'h03, 1'b0, 1'b0);
        wait_grant(0);
        @(posedge CLK); #1;
        REQ0_VALID = 1'b0;
        drive(1, 8'h0A, 8'h0B, 2'b00);
        push(1, 8'h15, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("hold_rsp0_valid", {31'b0, RSP0_VALID}, 32'd1);
            check("hold_rsp1_valid", {31'b0, RSP1_VALID}, 32'd0);
            check("hold_out", {24'b0, RSP_OUT}, 32'h03);
            check("hold_req_ready", {30'b0, REQ1_READY, REQ0_READY}, 32'd0);
        end
        @(posedge CLK); #1;
        RSP0_READY = 1'b1;
        wait_grant(1);
        @(posedge CLK); #1;
        REQ1_VALID = 1'b0;
        drain();

        // Reset while a result is held (pointer currently favours 1 after
        // the grant to 0 below), then a simultaneous request must go to 0.
        RSP0_READY = 1'b0;
        drive(0, 8'h7F, 8'h01, 2'b00);
        push(0, 8'h80, 1'b0, 1'b1);
        wait_grant(0);
        @(posedge CLK); #1;
        REQ0_VALID = 1'b0;
        @(negedge CLK);
        check("pre_rst_valid", {31'b0, RSP0_VALID}, 32'd1);
        check("pre_rst_out", {24'b0, RSP_OUT}, 32'h80);
        #2 RST = 1'b1;
        #1;
        check("async_rst_valid", {30'b0, RSP1_VALID, RSP0_VALID}, 32'd0);
        check("async_rst_out", {24'b0, RSP_OUT}, 32'h00);
        check("async_rst_c_ov", {30'b0, RSP_C_OUT, RSP_OVERFLOW}, 32'd0);
        sb.delete();
        @(posedge CLK); #1;
        RST = 1'b0;
        RSP0_READY = 1'b1;
        drive(0, 8'h22, 8'h11, 2'b00);   // 0x33
        drive(1, 8'h44, 8'h00, 2'b11);
        push(0, 8'h33, 1'b0, 1'b0);
        wait_grant(0);
        @(posedge CLK); #1;
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        drain();

        repeat (2) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arith_arbiter.md
ALU_ARITH_ARBITER -- requirements
Module: alu_arith_arbiter

Interface
REQ-001 Parameters: none; all widths are fixed (8-bit operands, 2-bit op select, two requesters).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; ports SHALL be named in the codebase's uppercase style:
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous active-high reset
- REQ0_VALID, REQ1_VALID  in  1  requester n presents an operation
- REQ0_READY, REQ1_READY  out  1  requester n's operation accepted this cycle
- REQ0_A, REQ1_A  in  8  operand A
- REQ0_B, REQ1_B  in  8  operand B
- REQ0_S, REQ1_S  in  2  op select: 00 add, 01 sub, 10 inc, 11 pass
- RSP0_VALID, RSP1_VALID  out  1  result for requester n held
- RSP0_READY, RSP1_READY  in  1  requester n consumes the result
- RSP_OUT  out  8  result byte, shared
- RSP_C_OUT  out  1  carry out, bit 8 of the sum
- RSP_OVERFLOW  out  1  signed overflow

Function
REQ-003 FSM states: IDLE and RESP.
- IDLE: arbitrate.
- RESP: a result is held until consumed.
REQ-004 In IDLE with at least one REQn_VALID, the block SHALL grant exactly one requester, assert its REQn_READY combinationally in that cycle, register the result, and enter RESP at the next edge.
REQ-005 Arbitration SHALL be round-robin:
- A priority pointer (reset 0) names the favoured requester.
- After each grant, the pointer SHALL point to the non-granted requester.
- A sole requester is always granted.
REQ-006 REQn_READY SHALL be 0 in RESP and 0 for a non-granted requester.
REQ-007 Arithmetic, 9-bit result {C_OUT,OUT} = A + SUMMAND + CIN:
- S=00: SUMMAND=B, CIN=0.
- S=01: SUMMAND=~B, CIN=1.
- S=10: SUMMAND=0, CIN=1.
- S=11: SUMMAND=0, CIN=0.
REQ-008 OVERFLOW SHALL be 1 iff A[7]==SUMMAND[7] and OUT[7]!=A[7].
REQ-009 In RESP, only the granted owner's RSPn_VALID SHALL be 1. RSP_OUT, RSP_C_OUT and RSP_OVERFLOW SHALL remain stable until the owner's RSPn_READY is sampled high.
REQ-010 On the edge where the owner's RSPn_READY=1 in RESP, the FSM SHALL return to IDLE and RSPn_VALID SHALL drop. The non-owner's RSP_READY SHALL be ignored.
REQ-011 Latency and throughput:
- Request accept to RSPn_VALID: 1 cycle.
- Sustained throughput: at most one operation per 2 cycles. There is no accept in the same cycle as a response handshake.
REQ-012 REQn_VALID deasserted before grant SHALL cause no state change. Operands are sampled only in the grant cycle.
REQ-013 Simultaneous REQ0_VALID and REQ1_VALID SHALL be resolved by the pointer alone. The loser keeps VALID and is granted on the next IDLE cycle.

Reset
REQ-014 On RST=1, the block SHALL asynchronously set:
- FSM = IDLE, pointer = 0.
- RSP0_VALID = RSP1_VALID = 0.
- RSP_OUT = 8'h00, RSP_C_OUT = 0, RSP_OVERFLOW = 0.
REQ-015 Reset asserted while in RESP SHALL discard the held result without any handshake. The first post-reset grant SHALL favour requester 0.

Structure
REQ-016 The op-select encodings (ADD, SUB, INC, PASS) and the FSM state encodings SHALL be defined once in a shared package used by all ALU blocks.
REQ-017 Arbitration SHALL be a sub-module rr_arbiter2 with:
- inputs: request pair, pointer.
- outputs: one-hot grant.
The arithmetic SHALL be implemented inline in alu_arith_arbiter.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- REQ0 only, A=8'h7F B=8'h01 S=00 -> REQ0_READY same cycle; next cycle RSP0_VALID=1, OUT=8'h80, C_OUT=0, OVERFLOW=1.
- REQ1 only, A=8'h05 B=8'h07 S=01 -> OUT=8'hFE, C_OUT=0, OVERFLOW=0. Then A=8'h80 B=8'h01 S=01 -> OUT=8'h7F, C_OUT=1, OVERFLOW=1.
- Both VALID continuously after reset -> grants alternate 0,1,0,1. Each result is routed to the matching RSPn_VALID.
- Owner holds RSPn_READY=0 for 5 cycles; the other requester is VALID throughout -> result stable, no REQ_READY asserted; grant follows only after consumption.
- A=8'hFF S=10 -> OUT=8'h00, C_OUT=1, OVERFLOW=0. A=8'h3C S=11 -> OUT=8'h3C, C_OUT=0.
- RST pulsed while in RESP -> outputs zero immediately (asynchronous). Next simultaneous request grants requester 0.
